// File: rtl/cpu_reg_file_if.sv
// cpu_reg_file_if
// Bundles the update controls going into the architectural register bank
// and the eight register buses (plus sp_wrap) coming back out of it.
// master : the control unit. It drives the update strobes and reads the buses.
// slave  : the register bank. It receives the strobes and drives the buses.
// Signals:
//   wr_en/wr_sel/wr_data    write-back strobe, target register, value
//   sp_inc/sp_dec/pc_inc    stack pointer and program counter steps
//   flag_mask/flag_data     masked update of P
//   a_out..tmp_out          register contents (mux inputs in0..in7)
//   sp_wrap                 one-cycle pulse after an SP wrap-around
interface cpu_reg_file_if #(
  parameter int REG_WIDTH = 8
);
  logic                 wr_en;
  logic [2:0]           wr_sel;
  logic [REG_WIDTH-1:0] wr_data;
  logic                 sp_inc;
  logic                 sp_dec;
  logic                 pc_inc;
  logic [7:0]           flag_mask;
  logic [7:0]           flag_data;
  logic [REG_WIDTH-1:0] a_out;
  logic [REG_WIDTH-1:0] x_out;
  logic [REG_WIDTH-1:0] y_out;
  logic [REG_WIDTH-1:0] sp_out;
  logic [REG_WIDTH-1:0] pcl_out;
  logic [REG_WIDTH-1:0] pch_out;
  logic [REG_WIDTH-1:0] p_out;
  logic [REG_WIDTH-1:0] tmp_out;
  logic                 sp_wrap;

  modport master (
    output wr_en, wr_sel, wr_data, sp_inc, sp_dec, pc_inc, flag_mask, flag_data,
    input  a_out, x_out, y_out, sp_out, pcl_out, pch_out, p_out, tmp_out, sp_wrap
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, sp_inc, sp_dec, pc_inc, flag_mask, flag_data,
    output a_out, x_out, y_out, sp_out, pcl_out, pch_out, p_out, tmp_out, sp_wrap
  );
endinterface

// File: rtl/cpu_reg_file.sv
// cpu_reg_file
// Architectural register bank of the 6502-compatible core. It holds A, X, Y,
// SP, PCL, PCH, P and TMP, and drives them as eight parallel registered buses
// into the operand mux. Write-back, SP step, 16-bit PC increment and the
// masked flag update all take effect on the same rising edge.
// Ports:
//   clk    system clock; all state updates on its rising edge
//   rst_n  asynchronous, active-low reset
//   bus    cpu_reg_file_if.slave (update controls in, register buses out)
module cpu_reg_file #(
  parameter int          REG_WIDTH = 8,
  parameter logic [15:0] RESET_PC  = 16'hFFFC,
  parameter logic [7:0]  RESET_SP  = 8'hFD
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_reg_file_if.slave bus
);

  localparam logic [REG_WIDTH-1:0] P_RESET = REG_WIDTH'(8'h34);
  // P bit 5 is unused on the 6502 and always reads as 1.
  localparam logic [REG_WIDTH-1:0] P_BIT5  = REG_WIDTH'(8'h20);
  localparam logic [REG_WIDTH-1:0] ONE     = REG_WIDTH'(1);

  logic [REG_WIDTH-1:0]   a_q, x_q, y_q, sp_q, pcl_q, pch_q, p_q, tmp_q;
  logic                   sp_wrap_q;

  logic [7:0]             wr_hit;
  logic [REG_WIDTH-1:0]   sp_next, pcl_next, pch_next, p_next;
  logic                   sp_wrap_next;
  logic [2*REG_WIDTH-1:0] pc_sum;
  logic [REG_WIDTH-1:0]   mask_w, fdata_w;

  // Next-state logic for the registers that have more than one update path.
  // A write-back always has priority over the increment/step/flag paths.
  always_comb begin
    wr_hit = '0;
    if (bus.wr_en) wr_hit[bus.wr_sel] = 1'b1;

    sp_next      = sp_q;
    sp_wrap_next = 1'b0;
    if (wr_hit[3]) begin
      sp_next = bus.wr_data;
    end else if (bus.sp_inc && !bus.sp_dec) begin
      sp_next      = sp_q + ONE;
      sp_wrap_next = (sp_q == '1);
    end else if (bus.sp_dec && !bus.sp_inc) begin
      sp_next      = sp_q - ONE;
      sp_wrap_next = (sp_q == '0);
    end

    // A write to either PC byte cancels the increment for the whole cycle,
    // so the byte that is not written simply holds.
    pc_sum   = {pch_q, pcl_q} + (2*REG_WIDTH)'(1);
    pcl_next = pcl_q;
    pch_next = pch_q;
    if (wr_hit[4] || wr_hit[5]) begin
      if (wr_hit[4]) pcl_next = bus.wr_data;
      if (wr_hit[5]) pch_next = bus.wr_data;
    end else if (bus.pc_inc) begin
      {pch_next, pcl_next} = pc_sum;
    end

    mask_w  = REG_WIDTH'(bus.flag_mask);
    fdata_w = REG_WIDTH'(bus.flag_data);
    if (wr_hit[6]) begin
      p_next = bus.wr_data | P_BIT5;
    end else begin
      p_next = (p_q & ~mask_w) | (fdata_w & mask_w) | P_BIT5;
    end
  end

  // Register bank. Everything holds while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sp_q      <= REG_WIDTH'(RESET_SP);
      pcl_q     <= REG_WIDTH'(RESET_PC[7:0]);
      pch_q     <= REG_WIDTH'(RESET_PC[15:8]);
      p_q       <= P_RESET;
      tmp_q     <= '0;
      sp_wrap_q <= 1'b0;
    end else begin
      if (wr_hit[0]) a_q   <= bus.wr_data;
      if (wr_hit[1]) x_q   <= bus.wr_data;
      if (wr_hit[2]) y_q   <= bus.wr_data;
      if (wr_hit[7]) tmp_q <= bus.wr_data;
      sp_q      <= sp_next;
      pcl_q     <= pcl_next;
      pch_q     <= pch_next;
      p_q       <= p_next;
      sp_wrap_q <= sp_wrap_next;
    end
  end

  assign bus.a_out   = a_q;
  assign bus.x_out   = x_q;
  assign bus.y_out   = y_q;
  assign bus.sp_out  = sp_q;
  assign bus.pcl_out = pcl_q;
  assign bus.pch_out = pch_q;
  assign bus.p_out   = p_q;
  assign bus.tmp_out = tmp_q;
  assign bus.sp_wrap = sp_wrap_q;

endmodule

// File: tb/tb_cpu_reg_file.sv
// tb_cpu_reg_file
// Scoreboard bench for cpu_reg_file. The stimulus process drives one vector
// per cycle on the falling edge and queues the hand-computed register values
// expected after the next rising edge. A monitor pops and compares them just
// after that edge. Asynchronous reset values are checked directly.
module tb_cpu_reg_file;

  logic clk;
  logic rst_n;
  int   edgeCount;
  int   checks;
  int   passes;

  typedef struct {
    int         edgeNo;
    int         idx;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sbQueue[$];

  cpu_reg_file_if #(.REG_WIDTH(8)) bus ();

  cpu_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to tag scoreboard entries.
  initial edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Index 0..7 selects the register buses in mux order. Index 8 selects sp_wrap.
  function automatic logic [7:0] readReg(int idx);
    case (idx)
      0:       return bus.a_out;
      1:       return bus.x_out;
      2:       return bus.y_out;
      3:       return bus.sp_out;
      4:       return bus.pcl_out;
      5:       return bus.pch_out;
      6:       return bus.p_out;
      7:       return bus.tmp_out;
      default: return {7'b0, bus.sp_wrap};
    endcase
  endfunction

  task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
    else
      passes++;
  endtask

  // Queues an expectation for the edge that follows the current drive.
  task automatic expectReg(int idx, logic [7:0] val, string name);
    exp_t e;
    e.edgeNo = edgeCount + 1;
    e.idx    = idx;
    e.val    = val;
    e.name   = name;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(logic we, logic [2:0] sel, logic [7:0] data,
                               logic spi, logic spd, logic pci,
                               logic [7:0] mask, logic [7:0] fdata);
    @(negedge clk);
    bus.wr_en     = we;
    bus.wr_sel    = sel;
    bus.wr_data   = data;
    bus.sp_inc    = spi;
    bus.sp_dec    = spd;
    bus.pc_inc    = pci;
    bus.flag_mask = mask;
    bus.flag_data = fdata;
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_a"},    bus.a_out,   8'h00);
    checkOutput({tag, "_x"},    bus.x_out,   8'h00);
    checkOutput({tag, "_y"},    bus.y_out,   8'h00);
    checkOutput({tag, "_sp"},   bus.sp_out,  8'hFD);
    checkOutput({tag, "_pcl"},  bus.pcl_out, 8'hFC);
    checkOutput({tag, "_pch"},  bus.pch_out, 8'hFF);
    checkOutput({tag, "_p"},    bus.p_out,   8'h34);
    checkOutput({tag, "_tmp"},  bus.tmp_out, 8'h00);
    checkOutput({tag, "_wrap"}, {7'b0, bus.sp_wrap}, 8'h00);
  endtask

  // Monitor: just after each rising edge, compare every entry tagged for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sbQueue.size() > 0 && sbQueue[0].edgeNo <= edgeCount) begin
        e = sbQueue.pop_front();
        checkOutput(e.name, readReg(e.idx), e.val);
      end
    end
  end

  logic [7:0] sweepData [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    int waitCycles;
    checks        = 0;
    passes        = 0;
    rst_n         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_sel    = 3'd0;
    bus.wr_data   = 8'h00;
    bus.sp_inc    = 1'b0;
    bus.sp_dec    = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.flag_mask = 8'h00;
    bus.flag_data = 8'h00;
    #1 rst_n = 1'b0;
    #1 checkResetValues("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write-back sweep across all eight targets.
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b1, 3'(s), sweepData[s], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      expectReg(s, sweepData[s], $sformatf("sweep_sel%0d", s));
      if (s == 3) expectReg(8, 8'h00, "sweep_sp_wrap");
    end

    // Asynchronous reset mid-cycle with every register dirty.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("async");
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 3'd0;
    bus.wr_data = 8'hAA;
    @(posedge clk);
    #1 checkOutput("reset_hold_a", bus.a_out, 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;

    // Stack pointer wrap-around.
    applyStimulus(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'h00, "sp_load00");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'hFF, "sp_dec_wrap");
    expectReg(8, 8'h01, "sp_dec_wrap_pulse");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'hFF, "sp_idle_hold");
    expectReg(8, 8'h00, "sp_wrap_one_cycle");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'h00, "sp_inc_wrap");
    expectReg(8, 8'h01, "sp_inc_wrap_pulse");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'h00, "sp_inc_dec_hold");
    expectReg(8, 8'h00, "sp_inc_dec_nowrap");
    applyStimulus(1'b1, 3'd3, 8'h42, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(3, 8'h42, "sp_write_overrides");
    expectReg(8, 8'h00, "sp_write_nowrap");

    // Program counter carry and write suppression.
    applyStimulus(1'b1, 3'd5, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(5, 8'h12, "pch_load12");
    expectReg(4, 8'hFC, "pcl_hold_fc");
    applyStimulus(1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(4, 8'hFF, "pcl_loadff");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    expectReg(4, 8'h00, "pc_carry_pcl");
    expectReg(5, 8'h13, "pc_carry_pch");
    applyStimulus(1'b1, 3'd5, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    expectReg(4, 8'h00, "pc_wrap_pcl");
    expectReg(5, 8'h00, "pc_wrap_pch");
    applyStimulus(1'b1, 3'd5, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 3'd4, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    expectReg(4, 8'h80, "pc_inc_pcl_write");
    expectReg(5, 8'h12, "pc_inc_pcl_write_pch");
    applyStimulus(1'b1, 3'd5, 8'h34, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    expectReg(5, 8'h34, "pc_inc_pch_write");
    expectReg(4, 8'h80, "pc_inc_pch_write_pcl");

    // Flag register.
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hFF);
    expectReg(6, 8'hF7, "p_mask_c3");
    applyStimulus(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    expectReg(6, 8'h20, "p_write_overrides");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
    expectReg(6, 8'h20, "p_bit5_forced");
    applyStimulus(1'b1, 3'd6, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    expectReg(6, 8'h2F, "p_write_0f");

    // Simultaneous X write, SP decrement, PC increment and flag update.
    applyStimulus(1'b1, 3'd1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
    expectReg(1, 8'h5A, "sim_x");
    expectReg(3, 8'h41, "sim_sp");
    expectReg(4, 8'h81, "sim_pcl");
    expectReg(5, 8'h34, "sim_pch");
    expectReg(6, 8'h2E, "sim_p");
    expectReg(0, 8'h00, "sim_a_hold");
    expectReg(7, 8'h00, "sim_tmp_hold");
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (sbQueue.size() > 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_reg_file.md
# cpu_reg_file

Architectural register bank for the 6502-compatible core. Holds A, X, Y, SP, PCL, PCH, P and an internal TMP register, and drives them as eight parallel buses straight into the 8:1 registered operand mux (`mux831`), with output index equal to the mux selector code. Provides write-back, stack-pointer increment/decrement, 16-bit PC increment, and masked flag update, all on a single clock edge.

## Interface
- REG_WIDTH, default `REG_WIDTH (8): data width of every register. Behaviour below is specified for 8.
- RESET_PC, default 16'hFFFC: PCH:PCL value loaded at reset.
- RESET_SP, default 8'hFD: SP value loaded at reset.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write-back strobe.
- wr_sel  in  3  target register: 0 A, 1 X, 2 Y, 3 SP, 4 PCL, 5 PCH, 6 P, 7 TMP.
- wr_data  in  REG_WIDTH  write-back value.
- sp_inc  in  1  SP = SP + 1.
- sp_dec  in  1  SP = SP − 1.
- pc_inc  in  1  {PCH,PCL} = {PCH,PCL} + 1.
- flag_mask  in  8  per-bit update enable for P.
- flag_data  in  8  new P bit values where mask is set.
- a_out, x_out, y_out, sp_out, pcl_out, pch_out, p_out, tmp_out  out  REG_WIDTH each  register contents, wired to mux inputs in0..in7 respectively.
- sp_wrap  out  1  one-cycle pulse on SP wrap-around.

## Operation
- Reset (rst_n low, asynchronous, any time, including mid-operation): A=X=Y=TMP=8'h00, SP=RESET_SP, PCL=RESET_PC[7:0], PCH=RESET_PC[15:8], P=8'h34, sp_wrap=0. State holds while rst_n is low. The first update occurs on the first rising edge after deassertion.
- Write-back: if wr_en is high, the selected register takes wr_data at the edge.
- SP: if sp_inc and sp_dec are both high, there is no change. Otherwise SP is incremented or decremented modulo 256.
  - wr_en with wr_sel=3 overrides both sp_inc and sp_dec.
  - sp_wrap is asserted for one cycle after an increment from 8'hFF→8'h00 or a decrement from 8'h00→8'hFF. It is not asserted on a write-back.
- PC: pc_inc adds 1 across 16 bits. The carry from PCL=FF propagates into PCH, and 16'hFFFF wraps to 16'h0000.
  - wr_en targeting PCL or PCH suppresses pc_inc entirely for that cycle. The written byte is loaded and the other byte holds.
- P: for each bit i with flag_mask[i]=1, P[i] is set to flag_data[i].
  - wr_en with wr_sel=6 overrides the masked update; the full wr_data is loaded.
  - Bit 5 is forced to 1 on every update path and reads as 1 always.
- All other registers hold when not addressed.
- Simultaneous operations on different registers all take effect in the same edge. Examples: write X + sp_dec + pc_inc + flag update.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- A write, increment or flag update sampled at edge N is visible on the *_out buses after edge N.
- The downstream mux samples the new value at edge N+1, so write-to-mux-output latency is 2 cycles.
- sp_wrap is high for exactly the cycle following the wrapping edge N, that is, between edges N and N+1.
- Throughput: one update of every register per cycle, with no stalls and no handshake.

## Test plan
- Reset values: assert rst_n low mid-cycle with registers dirty.
  - Outputs change immediately, without waiting for a clock edge.
  - Required values: a/x/y/tmp=00, sp=FD, pcl=FC, pch=FF, p=34.
- Write-back sweep: write 8'h11·(sel+1) to each wr_sel 0..7 in turn.
  - Each bus shows its value one edge later.
  - p_out reads 8'h77, because bit5 is forced to 1 (8'h77 already has bit5 set).
  - Muxing through `mux831` with selector=sel returns the value after 2 edges.
- SP wrap:
  - SP=00 + sp_dec → FF with sp_wrap=1 for 1 cycle.
  - Then sp_inc → 00 with sp_wrap=1.
  - sp_inc+sp_dec together → no change, sp_wrap=0.
  - wr_sel=3 write of 8'h42 together with sp_inc → SP=42, sp_wrap=0.
- PC carry:
  - PC=12FF + pc_inc → 1300.
  - FFFF + pc_inc → 0000.
  - PC=12FF, pc_inc with a PCL write of 8'h80 → PC=1280.
- Flags:
  - P=34, mask=8'hC3, data=8'hFF → P=F7.
  - Then wr_sel=6 write of 8'h00 together with mask=FF, data=FF → P=20.
